bias_bg_seq_ctrl: RTL and testbench
===================================

Name: bias_bg_seq_ctrl

Overview:
- Digital power-up sequencer for the EG1D80V bias/bandgap IO macro.
- Drives the macro's enable, bandgap-startup pulse, trim words and VBIAS enable.
- Monitors the macro's bandgap-valid flag and retries on timeout or loss of valid.
- Sits in the always-on domain between the chip configuration registers and the macro; one instance per macro.

Parameters:
- STARTUP_CYC, 16: cycles BG_STARTUP_O is held high per start attempt (>=1).
- SETTLE_CYC, 256: cycles after startup release during which valid is ignored (>=1).
- VALID_TIMEOUT, 1024: cycles to wait for valid before an attempt counts as failed (>=1).
- MAX_RETRY, 3: failed attempts allowed after the first before FAULT (0..7).
- CNT_W, 12: down-counter width; must hold max(STARTUP_CYC, SETTLE_CYC, VALID_TIMEOUT)-1.

Ports:
- CLK_I, in, 1: always-on clock.
- RST_I, in, 1: reset, asynchronous, active-high.
- REQ_EN_I, in, 1: request bias power-up; level-sensitive.
- REQ_VBIAS_I, in, 1: request VBIAS drive; honoured only in READY.
- TRIM_BIAS_CFG_I, in, 4: bias trim from config.
- TRIM_CURV_CFG_I, in, 5: curvature trim from config.
- TRIM_VBG_CFG_I, in, 5: bandgap trim from config.
- BG_VALID_N_I, in, 1: macro BG_VALID_N_O; asynchronous, active-low.
- EN_O, out, 1: to macro EN_I.
- BG_STARTUP_O, out, 1: to macro BG_STARTUP_I.
- EN_VBIAS_O, out, 1: to macro EN_VBIAS_I.
- TRIM_BIAS_O, out, 4: to macro TRIM_BIAS_I.
- TRIM_CURV_O, out, 5: to macro TRIM_CURV_I.
- TRIM_VBG_O, out, 5: to macro TRIM_VBG_I.
- READY_O, out, 1: bandgap valid and stable.
- FAIL_O, out, 1: retries exhausted; sticky.
- STATE_O, out, 3: current state encoding, for debug/status.

Behaviour:
- All outputs are registered. Reset values: EN_O=0, BG_STARTUP_O=0, EN_VBIAS_O=0, trims=0, READY_O=0, FAIL_O=0, STATE_O=OFF.
- BG_VALID_N_I passes through a 2-flop synchronizer (reset value 1) to give vn_s.
- States: OFF=0, STARTUP=1, SETTLE=2, WAIT_VALID=3, READY=4, FAULT=5.
- OFF:
  - All drives are 0 and the retry count is cleared.
  - When REQ_EN_I=1: latch the three CFG trims into the trim outputs, set EN_O=1 and BG_STARTUP_O=1, load the counter with STARTUP_CYC-1, go to STARTUP.
- STARTUP: count down. At 0, set BG_STARTUP_O=0, load SETTLE_CYC-1, go to SETTLE.
- SETTLE: vn_s is ignored. At 0, load VALID_TIMEOUT-1, go to WAIT_VALID.
- WAIT_VALID:
  - vn_s=0: go to READY, set READY_O=1, clear the retry count.
  - Counter reaches 0 with vn_s=1 (timeout): this is a failure.
- Failure handling (from WAIT_VALID timeout or READY loss):
  - If retry count < MAX_RETRY: increment it, set BG_STARTUP_O=1, load STARTUP_CYC-1, go to STARTUP. EN_O stays 1.
  - Otherwise: go to FAULT.
- READY:
  - EN_VBIAS_O is REQ_VBIAS_I registered, one cycle latency.
  - vn_s=1 for 2 consecutive cycles is a loss of valid. On loss: EN_VBIAS_O=0 and READY_O=0 on the same edge, then take the failure path.
  - A single-cycle glitch on vn_s is ignored.
- FAULT:
  - EN_O=0, BG_STARTUP_O=0, EN_VBIAS_O=0, FAIL_O=1.
  - Stays in FAULT while REQ_EN_I=1. When REQ_EN_I=0, go to OFF and clear FAIL_O.
- REQ_EN_I=0 in any state except FAULT: go to OFF on the next edge. All drives and READY_O go to 0, counter and retry count are cleared. This takes priority over every other transition.
- Trims change only on the OFF->STARTUP edge; they hold their value through FAULT.
- The counter never wraps: it holds at 0 until the state changes.
- Asynchronous reset mid-sequence returns to OFF immediately with reset values.

Optional Feature:
- Macro TRIM_LIVE_UPDATE_EN.
- When defined: in READY, the trim outputs follow the CFG inputs registered (1-cycle latency). Any change in trim value restarts a loss-of-valid grace window of SETTLE_CYC cycles, during which vn_s is ignored.
- When undefined: trims are latched only at OFF->STARTUP, and CFG changes have no effect until the next power-up.

Decomposition:
- Package bias_seq_pkg holds:
  - state enum and its 3-bit encoding;
  - trim width constants (4/5/5);
  - default parameter constants.
- One sub-module, bias_seq_sync: 2-flop synchronizer with a reset-value parameter.
- The FSM, counter and retry logic stay in the top module.

Test Plan:
- All tests use STARTUP_CYC=4, SETTLE_CYC=8, VALID_TIMEOUT=16, MAX_RETRY=2, with a behavioural macro model.
- Normal power-up: REQ_EN_I rises at edge 0 with CFG trims 4'hA/5'h11/5'h05.
  - Required: EN_O=1 from edge 0; BG_STARTUP_O high for edges 0..3.
  - Required: WAIT_VALID at edge 12; READY_O=1 at edge 13; trims equal CFG.
- VBIAS enable: in READY, REQ_VBIAS_I=1 -> EN_VBIAS_O=1 one cycle later. REQ_EN_I=0 -> EN_O, EN_VBIAS_O and READY_O all 0 the next cycle; STATE_O=0.
- Timeout retries: model holds valid_n=1.
  - Required: exactly 3 startup pulses, each 4 cycles wide.
  - Required: FAULT with FAIL_O=1 and EN_O=0 after the third timeout.
  - Required: FAIL_O clears only after REQ_EN_I=0.
- Loss in READY: force valid_n=1 for 1 cycle -> READY is held. Force it for 2 cycles -> EN_VBIAS_O=0, READY_O=0, STATE_O=STARTUP, BG_STARTUP_O=1.
- Reset mid-sequence: assert RST_I during SETTLE -> all outputs reach reset values immediately, with no clock edge required.
- TRIM_LIVE_UPDATE_EN: in READY, change TRIM_VBG_CFG_I from 5'h05 to 5'h06 -> TRIM_VBG_O=5'h06 one cycle later. A 2-cycle valid_n pulse inside the grace window does not drop READY_O. Without the macro, TRIM_VBG_O stays 5'h05.

Source files
------------

// File: rtl/bias_seq_pkg.sv
// Shared types and constants for the EG1D80V bias/bandgap power-up sequencer.
package bias_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_STARTUP    = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_WAIT_VALID = 3'd3,
    ST_READY      = 3'd4,
    ST_FAULT      = 3'd5
  } seqState_t;

  localparam int TRIM_BIAS_W = 4;
  localparam int TRIM_CURV_W = 5;
  localparam int TRIM_VBG_W  = 5;

  localparam int DEF_STARTUP_CYC   = 16;
  localparam int DEF_SETTLE_CYC    = 256;
  localparam int DEF_VALID_TIMEOUT = 1024;
  localparam int DEF_MAX_RETRY     = 3;
  localparam int DEF_CNT_W         = 12;

endpackage

// File: rtl/bias_seq_sync.sv
// Two-flop synchronizer with a configurable reset value.
module bias_seq_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bias_bg_seq_ctrl.sv
// Power-up sequencer for the EG1D80V bias/bandgap macro: startup pulse, settle, valid wait, retry.
// Optional build macro TRIM_LIVE_UPDATE_EN: trims track config while READY, with a loss-of-valid grace window.
module bias_bg_seq_ctrl
  import bias_seq_pkg::*;
#(
  parameter int STARTUP_CYC   = DEF_STARTUP_CYC,
  parameter int SETTLE_CYC    = DEF_SETTLE_CYC,
  parameter int VALID_TIMEOUT = DEF_VALID_TIMEOUT,
  parameter int MAX_RETRY     = DEF_MAX_RETRY,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic                   REQ_EN_I,
  input  logic                   REQ_VBIAS_I,
  input  logic [TRIM_BIAS_W-1:0] TRIM_BIAS_CFG_I,
  input  logic [TRIM_CURV_W-1:0] TRIM_CURV_CFG_I,
  input  logic [TRIM_VBG_W-1:0]  TRIM_VBG_CFG_I,
  input  logic                   BG_VALID_N_I,
  output logic                   EN_O,
  output logic                   BG_STARTUP_O,
  output logic                   EN_VBIAS_O,
  output logic [TRIM_BIAS_W-1:0] TRIM_BIAS_O,
  output logic [TRIM_CURV_W-1:0] TRIM_CURV_O,
  output logic [TRIM_VBG_W-1:0]  TRIM_VBG_O,
  output logic                   READY_O,
  output logic                   FAIL_O,
  output logic [2:0]             STATE_O
);

  localparam logic [CNT_W-1:0] STARTUP_LOAD = CNT_W'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(VALID_TIMEOUT - 1);
  localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRY);

  seqState_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       retryCnt;
  logic             vnS;
  logic             lossPend;
  logic             graceAct;
  logic             lossNow;
  logic             failEvt;

  bias_seq_sync #(.RST_VAL(1'b1)) uValidSync (
    .clk (CLK_I),
    .rst (RST_I),
    .d   (BG_VALID_N_I),
    .q   (vnS)
  );

  assign STATE_O = state;

  // Loss needs vn_s high on two consecutive READY cycles; lossPend remembers the first one.
  always_comb begin
    lossNow = (state == ST_READY) && vnS && lossPend && !graceAct;
    failEvt = ((state == ST_WAIT_VALID) && vnS && (cnt == '0)) || lossNow;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state        <= ST_OFF;
      cnt          <= '0;
      retryCnt     <= '0;
      lossPend     <= 1'b0;
      graceAct     <= 1'b0;
      EN_O         <= 1'b0;
      BG_STARTUP_O <= 1'b0;
      EN_VBIAS_O   <= 1'b0;
      READY_O      <= 1'b0;
      FAIL_O       <= 1'b0;
      TRIM_BIAS_O  <= '0;
      TRIM_CURV_O  <= '0;
      TRIM_VBG_O   <= '0;
    end else if (!REQ_EN_I && (state != ST_FAULT)) begin
      // Dropping the request wins over everything except the sticky fault; trims are kept.
      state        <= ST_OFF;
      cnt          <= '0;
      retryCnt     <= '0;
      lossPend     <= 1'b0;
      graceAct     <= 1'b0;
      EN_O         <= 1'b0;
      BG_STARTUP_O <= 1'b0;
      EN_VBIAS_O   <= 1'b0;
      READY_O      <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          // Only reached with REQ_EN_I high, so this is the power-up edge.
          TRIM_BIAS_O  <= TRIM_BIAS_CFG_I;
          TRIM_CURV_O  <= TRIM_CURV_CFG_I;
          TRIM_VBG_O   <= TRIM_VBG_CFG_I;
          EN_O         <= 1'b1;
          BG_STARTUP_O <= 1'b1;
          retryCnt     <= '0;
          cnt          <= STARTUP_LOAD;
          state        <= ST_STARTUP;
        end
        ST_STARTUP: begin
          if (cnt == '0) begin
            BG_STARTUP_O <= 1'b0;
            cnt          <= SETTLE_LOAD;
            state        <= ST_SETTLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            cnt   <= TIMEOUT_LOAD;
            state <= ST_WAIT_VALID;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT_VALID: begin
          if (!vnS) begin
            READY_O  <= 1'b1;
            retryCnt <= '0;
            cnt      <= '0;
            lossPend <= 1'b0;
            graceAct <= 1'b0;
            state    <= ST_READY;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_READY: begin
          EN_VBIAS_O <= REQ_VBIAS_I;
          lossPend   <= vnS && !graceAct;
`ifdef TRIM_LIVE_UPDATE_EN
          // Any trim change reopens a settle-length window in which valid is not monitored.
          if ({TRIM_BIAS_CFG_I, TRIM_CURV_CFG_I, TRIM_VBG_CFG_I} !=
              {TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O}) begin
            TRIM_BIAS_O <= TRIM_BIAS_CFG_I;
            TRIM_CURV_O <= TRIM_CURV_CFG_I;
            TRIM_VBG_O  <= TRIM_VBG_CFG_I;
            graceAct    <= 1'b1;
            cnt         <= SETTLE_LOAD;
          end else if (graceAct) begin
            if (cnt == '0) begin
              graceAct <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
`endif
        end
        ST_FAULT: begin
          if (!REQ_EN_I) begin
            FAIL_O   <= 1'b0;
            retryCnt <= '0;
            cnt      <= '0;
            state    <= ST_OFF;
          end
        end
        default: state <= ST_OFF;
      endcase

      // Shared failure path for valid timeout and loss of valid in READY.
      if (failEvt) begin
        READY_O    <= 1'b0;
        EN_VBIAS_O <= 1'b0;
        lossPend   <= 1'b0;
        graceAct   <= 1'b0;
        if (retryCnt < RETRY_MAX) begin
          retryCnt     <= retryCnt + 3'd1;
          BG_STARTUP_O <= 1'b1;
          cnt          <= STARTUP_LOAD;
          state        <= ST_STARTUP;
        end else begin
          EN_O         <= 1'b0;
          BG_STARTUP_O <= 1'b0;
          FAIL_O       <= 1'b1;
          cnt          <= '0;
          state        <= ST_FAULT;
        end
      end
    end
  end

endmodule

// File: tb/tb_bias_bg_seq_ctrl.sv
// Directed bench for bias_bg_seq_ctrl with a behavioural bandgap macro model.
module tb_bias_bg_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       reqEn;
  logic       reqVbias;
  logic [3:0] trimBiasCfg;
  logic [4:0] trimCurvCfg;
  logic [4:0] trimVbgCfg;
  logic       bgValidN;
  logic       enO, bgStartupO, enVbiasO, readyO, failO;
  logic [3:0] trimBiasO;
  logic [4:0] trimCurvO, trimVbgO;
  logic [2:0] stateO;

  // Macro model: valid asserts once enabled and out of startup, unless the bench holds it off.
  logic holdInvalid;
  logic forceHigh;
  assign bgValidN = holdInvalid | forceHigh | ~(enO & ~bgStartupO);

  int checkCnt = 0;
  int passCnt  = 0;

  always #5 clk = ~clk;

  bias_bg_seq_ctrl #(
    .STARTUP_CYC   (4),
    .SETTLE_CYC    (8),
    .VALID_TIMEOUT (16),
    .MAX_RETRY     (2),
    .CNT_W         (12)
  ) dut (
    .CLK_I           (clk),
    .RST_I           (rst),
    .REQ_EN_I        (reqEn),
    .REQ_VBIAS_I     (reqVbias),
    .TRIM_BIAS_CFG_I (trimBiasCfg),
    .TRIM_CURV_CFG_I (trimCurvCfg),
    .TRIM_VBG_CFG_I  (trimVbgCfg),
    .BG_VALID_N_I    (bgValidN),
    .EN_O            (enO),
    .BG_STARTUP_O    (bgStartupO),
    .EN_VBIAS_O      (enVbiasO),
    .TRIM_BIAS_O     (trimBiasO),
    .TRIM_CURV_O     (trimCurvO),
    .TRIM_VBG_O      (trimVbgO),
    .READY_O         (readyO),
    .FAIL_O          (failO),
    .STATE_O         (stateO)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (readyO === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; reqEn = 1'b0; reqVbias = 1'b0;
    trimBiasCfg = 4'h3; trimCurvCfg = 5'h07; trimVbgCfg = 5'h09;
    holdInvalid = 1'b0; forceHigh = 1'b0;
    tick(); tick();
    checkCnt++; if ({enO, bgStartupO, enVbiasO, readyO, failO} !== 5'b0)
      $display("FAIL reset_flags got=%b exp=00000", {enO, bgStartupO, enVbiasO, readyO, failO}); else passCnt++;
    checkCnt++; if ({trimBiasO, trimCurvO, trimVbgO} !== 14'h0)
      $display("FAIL reset_trims got=%h exp=0", {trimBiasO, trimCurvO, trimVbgO}); else passCnt++;
    checkCnt++; if (stateO !== 3'd0) $display("FAIL reset_state got=%0d exp=0", stateO); else passCnt++;
    rst = 1'b0;
    tick();
    checkCnt++; if (stateO !== 3'd0 || enO !== 1'b0)
      $display("FAIL idle_off got state=%0d en=%b exp state=0 en=0", stateO, enO); else passCnt++;
  endtask

  task automatic test_power_up();
    logic [2:0] expState;
    trimBiasCfg = 4'hA; trimCurvCfg = 5'h11; trimVbgCfg = 5'h05;
    reqEn = 1'b1;
    for (int e = 0; e <= 13; e++) begin
      tick();
      expState = (e <= 3) ? 3'd1 : (e <= 11) ? 3'd2 : (e == 12) ? 3'd3 : 3'd4;
      checkCnt++; if (enO !== 1'b1) $display("FAIL pu_en edge=%0d got=%b exp=1", e, enO); else passCnt++;
      checkCnt++; if (bgStartupO !== (e <= 3))
        $display("FAIL pu_startup edge=%0d got=%b exp=%b", e, bgStartupO, (e <= 3)); else passCnt++;
      checkCnt++; if (stateO !== expState)
        $display("FAIL pu_state edge=%0d got=%0d exp=%0d", e, stateO, expState); else passCnt++;
      checkCnt++; if (readyO !== (e >= 13))
        $display("FAIL pu_ready edge=%0d got=%b exp=%b", e, readyO, (e >= 13)); else passCnt++;
    end
    checkCnt++; if ({trimBiasO, trimCurvO, trimVbgO} !== {4'hA, 5'h11, 5'h05})
      $display("FAIL pu_trims got=%h/%h/%h exp=a/11/05", trimBiasO, trimCurvO, trimVbgO); else passCnt++;
  endtask

  task automatic test_vbias();
    reqVbias = 1'b1;
    #1;
    checkCnt++; if (enVbiasO !== 1'b0) $display("FAIL vbias_before got=%b exp=0", enVbiasO); else passCnt++;
    tick();
    checkCnt++; if (enVbiasO !== 1'b1) $display("FAIL vbias_on got=%b exp=1", enVbiasO); else passCnt++;
    reqEn = 1'b0;
    tick();
    checkCnt++; if ({enO, enVbiasO, readyO} !== 3'b000)
      $display("FAIL vbias_off got en/vb/rdy=%b exp=000", {enO, enVbiasO, readyO}); else passCnt++;
    checkCnt++; if (stateO !== 3'd0) $display("FAIL vbias_off_state got=%0d exp=0", stateO); else passCnt++;
    reqVbias = 1'b0;
  endtask

  task automatic test_timeout();
    int  pulses = 0;
    int  width  = 0;
    int  faultEdge = -1;
    bit  prevBgs = 1'b0;
    bit  faultSeen = 1'b0;
    holdInvalid = 1'b1;
    reqEn = 1'b1;
    // Each attempt spans 4 startup + 8 settle + 16 timeout cycles, so FAULT lands on edge 84.
    for (int e = 0; e < 150 && !faultSeen; e++) begin
      tick();
      if (bgStartupO && !prevBgs) begin pulses++; width = 0; end
      if (bgStartupO) width++;
      if (!bgStartupO && prevBgs) begin
        checkCnt++; if (width !== 4) $display("FAIL to_width pulse=%0d got=%0d exp=4", pulses, width); else passCnt++;
      end
      prevBgs = bgStartupO;
      if (stateO === 3'd5) begin faultSeen = 1'b1; faultEdge = e; end
    end
    checkCnt++; if (faultEdge !== 84) $display("FAIL to_fault_edge got=%0d exp=84", faultEdge); else passCnt++;
    checkCnt++; if (pulses !== 3) $display("FAIL to_pulses got=%0d exp=3", pulses); else passCnt++;
    checkCnt++; if ({failO, enO, bgStartupO} !== 3'b100)
      $display("FAIL to_fault_out got fail/en/bgs=%b exp=100", {failO, enO, bgStartupO}); else passCnt++;
    checkCnt++; if (trimVbgO !== 5'h05) $display("FAIL to_trim_hold got=%h exp=05", trimVbgO); else passCnt++;
    repeat (5) tick();
    checkCnt++; if (failO !== 1'b1 || stateO !== 3'd5)
      $display("FAIL to_sticky got fail=%b state=%0d exp fail=1 state=5", failO, stateO); else passCnt++;
    reqEn = 1'b0; holdInvalid = 1'b0;
    tick();
    checkCnt++; if (failO !== 1'b0 || stateO !== 3'd0)
      $display("FAIL to_clear got fail=%b state=%0d exp fail=0 state=0", failO, stateO); else passCnt++;
  endtask

  task automatic test_loss();
    bit ok;
    reqEn = 1'b1;
    wait_ready(ok);
    checkCnt++; if (!ok) $display("FAIL loss_ready got=0 exp=1"); else passCnt++;
    reqVbias = 1'b1;
    tick();
    forceHigh = 1'b1;
    tick();
    forceHigh = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkCnt++; if (readyO !== 1'b1 || stateO !== 3'd4)
        $display("FAIL glitch_hold cyc=%0d got rdy=%b state=%0d exp rdy=1 state=4", i, readyO, stateO); else passCnt++;
    end
    forceHigh = 1'b1;
    tick(); tick();
    forceHigh = 1'b0;
    tick();
    checkCnt++; if (readyO !== 1'b1) $display("FAIL loss_first got rdy=%b exp=1", readyO); else passCnt++;
    tick();
    checkCnt++; if ({enVbiasO, readyO, bgStartupO} !== 3'b001)
      $display("FAIL loss_out got vb/rdy/bgs=%b exp=001", {enVbiasO, readyO, bgStartupO}); else passCnt++;
    checkCnt++; if (stateO !== 3'd1) $display("FAIL loss_state got=%0d exp=1", stateO); else passCnt++;
    reqEn = 1'b0; reqVbias = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    reqEn = 1'b1;
    repeat (7) tick();
    checkCnt++; if (stateO !== 3'd2) $display("FAIL rm_settle got=%0d exp=2", stateO); else passCnt++;
    #2 rst = 1'b1;
    #1;
    checkCnt++; if ({enO, bgStartupO, enVbiasO, readyO, failO} !== 5'b0 || stateO !== 3'd0)
      $display("FAIL rm_async got flags=%b state=%0d exp 00000/0", {enO, bgStartupO, enVbiasO, readyO, failO}, stateO);
    else passCnt++;
    checkCnt++; if ({trimBiasO, trimCurvO, trimVbgO} !== 14'h0)
      $display("FAIL rm_trims got=%h exp=0", {trimBiasO, trimCurvO, trimVbgO}); else passCnt++;
    reqEn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_trim();
    bit ok;
    trimBiasCfg = 4'hA; trimCurvCfg = 5'h11; trimVbgCfg = 5'h05;
    reqEn = 1'b1;
    wait_ready(ok);
    checkCnt++; if (!ok) $display("FAIL trim_ready got=0 exp=1"); else passCnt++;
    checkCnt++; if (trimVbgO !== 5'h05) $display("FAIL trim_init got=%h exp=05", trimVbgO); else passCnt++;
    trimVbgCfg = 5'h06;
    tick();
`ifdef TRIM_LIVE_UPDATE_EN
    checkCnt++; if (trimVbgO !== 5'h06) $display("FAIL trim_live got=%h exp=06", trimVbgO); else passCnt++;
    forceHigh = 1'b1;
    tick(); tick();
    forceHigh = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkCnt++; if (readyO !== 1'b1)
        $display("FAIL trim_grace cyc=%0d got rdy=%b exp=1", i, readyO); else passCnt++;
    end
`else
    checkCnt++; if (trimVbgO !== 5'h05) $display("FAIL trim_latched got=%h exp=05", trimVbgO); else passCnt++;
    repeat (3) tick();
    checkCnt++; if (trimVbgO !== 5'h05 || readyO !== 1'b1)
      $display("FAIL trim_hold got trim=%h rdy=%b exp 05/1", trimVbgO, readyO); else passCnt++;
`endif
    reqEn = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_vbias();
    test_timeout();
    test_loss();
    test_reset_mid();
    test_trim();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
